// File: rtl/st4_mem_pkg.sv
// Shared definitions for the stage-4 data memory arbiter and its memory interface.
package st4_mem_pkg;

  // Memory operation codes on mem_MemWrite / mem_MemRead.
  localparam logic [1:0] MEM_OP_NONE = 2'b00;
  localparam logic [1:0] MEM_OP_WORD = 2'b01;
  localparam logic [1:0] MEM_OP_BYTE = 2'b10;

  // Arbiter FSM: RMW_WR is the write half of a byte-store read-modify-write.
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/st4_mem_prio.sv
// Two-port grant logic with a saturating starvation counter for port 1.
module st4_mem_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic p0_valid,
  input  logic p1_valid,
  output logic grant0,
  output logic grant1
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // One grant per cycle: a starved port 1 first, then port 0, then port 1.
  always_comb begin
    starved = (starve_cnt == CNT_W'(STARVE_MAX));
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (arb_en) begin
      if (p1_valid && starved) begin
        grant1 = 1'b1;
      end else if (p0_valid) begin
        grant0 = 1'b1;
      end else if (p1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Count cycles port 1 waits; grants are blocked outside IDLE, so waiting there counts too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant1) begin
      starve_cnt <= '0;
    end else if (p1_valid && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/st4_mem_arbiter.sv
// Stage-4 data memory arbiter: pipeline MEM stage (port 0) vs. loader/debug (port 1).
// Byte stores are done as read-modify-write so the upper byte is preserved.
module st4_mem_arbiter
  import st4_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p0_write,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  output logic              p0_stall,
  input  logic              p1_valid,
  input  logic              p1_write,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [1:0]        mem_MemWrite,
  output logic [1:0]        mem_MemRead,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  arb_state_e        state, state_nxt;
  logic              grant0, grant1;
  logic              sel_write, sel_byte, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] load_data;
  logic              rmw_start;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_data;

  st4_mem_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .arb_en  ((state == IDLE) && rst),
    .p0_valid(p0_valid),
    .p1_valid(p1_valid),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign p0_ready = grant0;
  assign p1_ready = grant1;
  assign p0_stall = p0_valid & ~grant0;

  // Select the granted request's fields and shape the load result.
  always_comb begin
    sel_write = p0_write;
    sel_byte  = p0_byte;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (grant1) begin
      sel_write = p1_write;
      sel_byte  = p1_byte;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
    sel_oor = (sel_addr >= ADDR_W'(DEPTH));
    if (sel_oor) begin
      load_data = '0;
    end else if (sel_byte) begin
      load_data = {{(DATA_W-8){1'b0}}, mem_ReadData[7:0]};
    end else begin
      load_data = mem_ReadData;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memory controls; out-of-range accesses touch nothing.
  always_comb begin
    state_nxt     = state;
    mem_MemWrite  = MEM_OP_NONE;
    mem_MemRead   = MEM_OP_NONE;
    mem_Address   = '0;
    mem_WriteData = '0;
    rmw_start     = 1'b0;
    case (state)
      IDLE: begin
        if ((grant0 || grant1) && !sel_oor) begin
          mem_Address = sel_addr;
          if (!sel_write) begin
            mem_MemRead = sel_byte ? MEM_OP_BYTE : MEM_OP_WORD;
          end else if (!sel_byte) begin
            mem_MemWrite  = MEM_OP_WORD;
            mem_WriteData = sel_wdata;
          end else begin
            mem_MemRead = MEM_OP_WORD;
            rmw_start   = 1'b1;
            state_nxt   = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_MemWrite  = MEM_OP_WORD;
        mem_Address   = rmw_addr;
        mem_WriteData = rmw_data;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      mem_MemWrite  = MEM_OP_NONE;
      mem_MemRead   = MEM_OP_NONE;
      mem_Address   = '0;
      mem_WriteData = '0;
    end
  end

  // Capture the merged word for the write half of a byte store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rmw_addr <= '0;
      rmw_data <= '0;
    end else if (rmw_start) begin
      rmw_addr <= sel_addr;
      rmw_data <= {mem_ReadData[DATA_W-1:8], sel_wdata[7:0]};
    end
  end

  // Response registers: rvalid/err pulse one cycle after accept, rdata holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= grant0 && !sel_write;
      p1_rvalid <= grant1 && !sel_write;
      p0_err    <= grant0 && sel_oor;
      p1_err    <= grant1 && sel_oor;
      if (grant0 && !sel_write) begin
        p0_rdata <= load_data;
      end
      if (grant1 && !sel_write) begin
        p1_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_st4_mem_arbiter.sv
// Self-checking bench for st4_mem_arbiter: transaction-level reference model,
// response scoreboard and a behavioural data memory.
module tb_st4_mem_arbiter;
  import st4_mem_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SMAX  = 4;
  localparam int unsigned IW    = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic          write;
    logic          bytes;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int            due;
    bit            port;
    bit            rv;
    bit            err;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  req_t req [2];

  logic          p0_ready, p0_rvalid, p0_err, p0_stall;
  logic          p1_ready, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [1:0]    mem_MemWrite, mem_MemRead;
  logic [AW-1:0] mem_Address;
  logic [DW-1:0] mem_WriteData, mem_ReadData;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          q [$];
  logic [DW-1:0] held [2];

  st4_mem_arbiter #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_valid     (req[0].valid),
    .p0_write     (req[0].write),
    .p0_byte      (req[0].bytes),
    .p0_addr      (req[0].addr),
    .p0_wdata     (req[0].wdata),
    .p0_ready     (p0_ready),
    .p0_rvalid    (p0_rvalid),
    .p0_rdata     (p0_rdata),
    .p0_err       (p0_err),
    .p0_stall     (p0_stall),
    .p1_valid     (req[1].valid),
    .p1_write     (req[1].write),
    .p1_byte      (req[1].bytes),
    .p1_addr      (req[1].addr),
    .p1_wdata     (req[1].wdata),
    .p1_ready     (p1_ready),
    .p1_rvalid    (p1_rvalid),
    .p1_rdata     (p1_rdata),
    .p1_err       (p1_err),
    .mem_MemWrite (mem_MemWrite),
    .mem_MemRead  (mem_MemRead),
    .mem_Address  (mem_Address),
    .mem_WriteData(mem_WriteData),
    .mem_ReadData (mem_ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read of the full word (the arbiter does the byte zero-extension).
  always_comb begin
    mem_ReadData = '0;
    if (mem_Address < AW'(DEPTH) && mem_MemRead != MEM_OP_NONE) begin
      mem_ReadData = mem[mem_Address[IW-1:0]];
    end
  end

  // Memory write port.
  always @(posedge clk) begin
    if (mem_MemWrite == MEM_OP_WORD && mem_Address < AW'(DEPTH)) begin
      mem[mem_Address[IW-1:0]] <= mem_WriteData;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model, evaluated mid-cycle: who should be granted, what the memory bus
  // should show, and which response is owed next cycle.
  int            starve = 0;
  bit            rmw_busy = 1'b0;
  bit            next_busy;
  logic [AW-1:0] rmw_a;
  logic [DW-1:0] rmw_d;
  bit            acc [2];
  bit            mg0, mg1, moor;
  logic [1:0]    ew, er;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;
  req_t          cur;
  rsp_t          mr;

  always @(negedge clk) begin
    if (!rst) begin
      starve   = 0;
      rmw_busy = 1'b0;
      acc[0]   = 1'b0;
      acc[1]   = 1'b0;
    end else begin
      mg0 = 1'b0;
      mg1 = 1'b0;
      if (!rmw_busy) begin
        if (req[1].valid && starve == SMAX) mg1 = 1'b1;
        else if (req[0].valid)              mg0 = 1'b1;
        else if (req[1].valid)              mg1 = 1'b1;
      end
      check("ready_stall", 64'({p1_ready, p0_ready, p0_stall}),
            64'({mg1, mg0, req[0].valid & ~mg0}));
      ew = MEM_OP_NONE; er = MEM_OP_NONE; ea = '0; ed = '0;
      next_busy = 1'b0;
      if (rmw_busy) begin
        ew = MEM_OP_WORD; ea = rmw_a; ed = rmw_d;
        ref_mem[rmw_a[IW-1:0]] = rmw_d;
      end
      if (mg0 || mg1) begin
        cur  = mg1 ? req[1] : req[0];
        moor = (cur.addr >= AW'(DEPTH));
        mr.due = cyc + 1; mr.port = mg1; mr.err = moor; mr.rv = 1'b0; mr.data = '0;
        if (!cur.write) begin
          mr.rv = 1'b1;
          if (!moor) begin
            mr.data = cur.bytes ? {8'h00, ref_mem[cur.addr[IW-1:0]][7:0]} : ref_mem[cur.addr[IW-1:0]];
            er = cur.bytes ? MEM_OP_BYTE : MEM_OP_WORD;
            ea = cur.addr;
          end
          q.push_back(mr);
        end else if (moor) begin
          q.push_back(mr);
        end else if (!cur.bytes) begin
          ew = MEM_OP_WORD; ea = cur.addr; ed = cur.wdata;
          ref_mem[cur.addr[IW-1:0]] = cur.wdata;
        end else begin
          er = MEM_OP_WORD; ea = cur.addr;
          next_busy = 1'b1;
          rmw_a = cur.addr;
          rmw_d = {ref_mem[cur.addr[IW-1:0]][15:8], cur.wdata[7:0]};
        end
      end
      check("mem_bus", 64'({mem_MemWrite, mem_MemRead, mem_Address, mem_WriteData}),
            64'({ew, er, ea, ed}));
      rmw_busy = next_busy;
      if (mg1) starve = 0;
      else if (req[1].valid && starve < SMAX) starve++;
      acc[0] = mg0;
      acc[1] = mg1;
    end
  end

  // Response monitor: pops the owed response when due and compares port outputs.
  logic [1:0] pres;
  rsp_t       r;
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      held[0] = '0;
      held[1] = '0;
    end else begin
      pres = {p1_rvalid | p1_err, p0_rvalid | p0_err};
      if (q.size() != 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        check("rsp_port", 64'(pres), r.port ? 64'd2 : 64'd1);
        if (r.rv) held[r.port] = r.data;
        if (r.port) check("p1_rsp", 64'({p1_rvalid, p1_err, p1_rdata}), 64'({r.rv, r.err, held[1]}));
        else        check("p0_rsp", 64'({p0_rvalid, p0_err, p0_rdata}), 64'({r.rv, r.err, held[0]}));
      end else if (pres != 2'b00) begin
        check("unexpected_rsp", 64'(pres), 64'd0);
      end else begin
        check("p0_hold", 64'(p0_rdata), 64'(held[0]));
        check("p1_hold", 64'(p1_rdata), 64'(held[1]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit w, input bit b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[n].valid = 1'b1;
    req[n].write = w;
    req[n].bytes = b;
    req[n].addr  = a;
    req[n].wdata = d;
  endtask

  // Hold port n's request until the model sees it accepted, then drop it after the edge.
  task automatic wait_acc(input int n, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #1;
      cycles++;
      got = acc[n];
    end
    if (!got) check("accept_timeout", 64'(got), 64'd1);
    step();
    req[n].valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int            c, p0n;
  bit            got1;
  logic [DW-1:0] saved;

  initial begin
    req[0] = '0;
    req[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 16'h2BCD; mem[4] = 16'h1234; mem[6] = 16'hDEAD; mem[8] = 16'hBEEF;
    ref_mem[0] = 16'h2BCD; ref_mem[4] = 16'h1234; ref_mem[6] = 16'hDEAD; ref_mem[8] = 16'hBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 64'({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err,
                             mem_MemWrite, mem_MemRead}), 64'd0);
    check("reset_rdata", 64'({p0_rdata, p1_rdata}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Word load of a preloaded word.
    set_req(0, 1'b0, 1'b0, 16'd4, 16'h0);
    wait_acc(0, c);

    // Byte store with a following load held valid through the RMW write cycle.
    set_req(0, 1'b1, 1'b1, 16'd0, 16'h0077);
    wait_acc(0, c);
    set_req(0, 1'b0, 1'b0, 16'd0, 16'h0);
    wait_acc(0, c);
    check("rmw_stall_cycles", 64'(c), 64'd2);

    // Port 0 hogging: port 1 must win once it has waited SMAX cycles.
    set_req(0, 1'b0, 1'b0, 16'd4, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'd0, 16'h0);
    p0n  = 0;
    got1 = 1'b0;
    for (int i = 0; i < 20 && !got1; i++) begin
      @(negedge clk);
      #1;
      if (acc[1]) got1 = 1'b1;
      else if (acc[0]) p0n++;
    end
    check("starve_p1_granted", 64'(got1), 64'd1);
    check("starve_p0_grants", 64'(p0n), 64'(SMAX));
    step();
    req[0].valid = 1'b0;
    req[1].valid = 1'b0;
    step();

    // Simultaneous loads: port 0 word, port 1 byte.
    set_req(0, 1'b0, 1'b0, 16'd6, 16'h0);
    set_req(1, 1'b0, 1'b1, 16'd8, 16'h0);
    wait_acc(0, c);
    wait_acc(1, c);
    check("p1_after_p0_wait", 64'(c), 64'd1);

    // Out-of-range load on port 1.
    set_req(1, 1'b0, 1'b0, 16'h0020, 16'h0);
    wait_acc(1, c);

    // Random traffic on both ports.
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n].valid || acc[n]) begin
          if ($urandom_range(0, 3) != 0) begin
            req[n].valid = 1'b1;
            req[n].write = 1'($urandom_range(0, 1));
            req[n].bytes = 1'($urandom_range(0, 1));
            req[n].addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, DEPTH + 40))
                                                       : AW'($urandom_range(0, DEPTH - 1));
            req[n].wdata = DW'($urandom);
          end else begin
            req[n].valid = 1'b0;
          end
        end
      end
      step();
    end
    req[0].valid = 1'b0;
    req[1].valid = 1'b0;
    repeat (3) step();

    // Reset during the write half of a byte store aborts the write.
    saved = mem[2];
    set_req(0, 1'b1, 1'b1, 16'd2, 16'h00A5);
    @(negedge clk);
    #1;
    check("rmw_abort_accept", 64'(acc[0]), 64'd1);
    @(posedge clk);
    #1;
    req[0].valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_abort_ctrl", 64'({mem_MemWrite, mem_MemRead, mem_Address, mem_WriteData}), 64'd0);
    @(posedge clk);
    #1;
    check("rst_abort_mem", 64'(mem[2]), 64'(saved));
    check("rst_outs", 64'({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err,
                           p0_rdata, p1_rdata}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    set_req(0, 1'b0, 1'b0, 16'd2, 16'h0);
    wait_acc(0, c);
    check("post_rst_immediate_grant", 64'(c), 64'd1);
    repeat (2) step();

    for (int i = 0; i < DEPTH; i++) begin
      check("mem_final", 64'(mem[i]), 64'(ref_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
